// File: rtl/flash_pp_pkg.sv
// Shared encodings for the parallel-programming controller: commands, XA codes, FSM states, bank selects.
// Pure declarations; no timing or flow control of its own.
package flash_pp_pkg;

   localparam logic [7:0] CMD_NOP        = 8'h00;
   localparam logic [7:0] CMD_CHIP_ERASE = 8'h80;
   localparam logic [7:0] CMD_WRITE      = 8'h10;
   localparam logic [7:0] CMD_READ       = 8'h02;

   localparam logic [1:0] XA_ADDR = 2'b00;
   localparam logic [1:0] XA_DATA = 2'b01;
   localparam logic [1:0] XA_CMD  = 2'b10;

   localparam logic [1:0] BKSEL_IDLE = 2'b00;
   localparam logic [1:0] BKSEL_APP  = 2'b01;
   localparam logic [1:0] BKSEL_BOOT = 2'b10;
   localparam logic [1:0] BKSEL_PROG = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE_LOAD,
      ST_PAGE_ERASE,
      ST_PAGE_PROG,
      ST_CHIP_ERASE,
      ST_READ
   } state_e;

   function automatic logic cmd_known(input logic [7:0] c);
      return (c == CMD_NOP) || (c == CMD_CHIP_ERASE) || (c == CMD_WRITE) || (c == CMD_READ);
   endfunction

   // A zero duration still has to occupy one cycle so the FSM visibly passes through the state.
   function automatic int eff_cyc(input int c);
      return (c <= 0) ? 1 : c;
   endfunction

endpackage

// File: rtl/flash_pp_ctrl_edge_det.sv
// Single-edge detector: samples d each clk, edge_o = combinational edge against the sampled copy (same-cycle).
// No flow control; one pulse per transition.
module edge_det #(
   parameter bit FALL    = 1'b0,
   parameter bit RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic edge_o
);

   logic d_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) d_q <= RST_VAL;
      else        d_q <= d;
   end

   assign edge_o = FALL ? (~d & d_q) : (d & ~d_q);

endmodule

// File: rtl/flash_pp_ctrl.sv
// Programming-pin decoder, page loader and erase/program sequencer with CPU fetch arbitration; 1-cycle register latency.
// No backpressure on the pins: strobes arriving while busy are dropped, CPU fetches into the busy section stall.
module flash_pp_ctrl
   import flash_pp_pkg::*;
#(
   parameter int ADDR_W         = 14,
   parameter int PAGE_WORDS     = 64,
   parameter int BOOT_MSBS      = 3,
   parameter int ERASE_CYC      = 100,
   parameter int PROG_CYC       = 100,
   parameter int CHIP_ERASE_CYC = 200
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          xtal1,
   input  logic [1:0]                    xa,
   input  logic                          bs1,
   input  logic                          wr_n,
   input  logic                          oe_n,
   input  logic [7:0]                    data_in,
   input  logic                          pc_rd,
   input  logic [ADDR_W-1:0]             pc,
   input  logic [15:0]                   mem_rdata,
   output logic                          rdy,
   output logic [7:0]                    data_out,
   output logic                          data_oe,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic                          mem_rd,
   output logic                          pb_we,
   output logic [$clog2(PAGE_WORDS)-1:0] pb_idx,
   output logic [15:0]                   pb_wdata,
   output logic                          erase,
   output logic                          prog,
   output logic                          chip_erase,
   output logic [1:0]                    bksel,
   output logic                          cpu_stall
);

   localparam int PI_W    = $clog2(PAGE_WORDS);
   localparam int E_EFF   = eff_cyc(ERASE_CYC);
   localparam int P_EFF   = eff_cyc(PROG_CYC);
   localparam int C_EFF   = eff_cyc(CHIP_ERASE_CYC);
   localparam int EP_MAX  = (E_EFF > P_EFF) ? E_EFF : P_EFF;
   localparam int MAX_CYC = (EP_MAX > C_EFF) ? EP_MAX : C_EFF;
   localparam int TMR_W   = $clog2(MAX_CYC) + 1;

   localparam logic [TMR_W-1:0] E_LD = TMR_W'(E_EFF - 1);
   localparam logic [TMR_W-1:0] P_LD = TMR_W'(P_EFF - 1);
   localparam logic [TMR_W-1:0] C_LD = TMR_W'(C_EFF - 1);

   logic xtal_rise, wr_fall;

   edge_det #(.FALL(1'b0), .RST_VAL(1'b0)) u_xtal_edge (
      .clk(clk), .rst_n(rst_n), .d(xtal1), .edge_o(xtal_rise)
   );

   edge_det #(.FALL(1'b1), .RST_VAL(1'b1)) u_wr_edge (
      .clk(clk), .rst_n(rst_n), .d(wr_n), .edge_o(wr_fall)
   );

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d, busy_addr_q, busy_addr_d, mem_addr_q, mem_addr_d;
   logic [7:0]          dlo_q, dlo_d, cmd_q, cmd_d;
   logic [TMR_W-1:0]    timer_q, timer_d;
   logic                rdy_q, rdy_d, erase_q, erase_d, prog_q, prog_d, chip_erase_q, chip_erase_d;
   logic                pb_we_q, pb_we_d, mem_rd_q, mem_rd_d, data_oe_q, data_oe_d;
   logic                rd_iss_q, rd_iss_d, cpu_stall_q, cpu_stall_d;
   logic [PI_W-1:0]     pb_idx_q, pb_idx_d;
   logic [15:0]         pb_wdata_q, pb_wdata_d;
   logic [1:0]          bksel_q, bksel_d;

   logic cmd_evt, busy_now, busy_d, rd_now, pc_boot, page_boot, same_sec;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      dlo_d       = dlo_q;
      cmd_d       = cmd_q;
      timer_d     = timer_q;
      busy_addr_d = busy_addr_q;
      pb_we_d     = 1'b0;
      pb_idx_d    = pb_idx_q;
      pb_wdata_d  = pb_wdata_q;
      cmd_evt     = 1'b0;
      busy_now    = (state_q == ST_PAGE_ERASE) || (state_q == ST_PAGE_PROG) ||
                    (state_q == ST_CHIP_ERASE);

      if (xtal_rise && !busy_now) begin
         unique case (xa)
            XA_ADDR: begin
               if (bs1) addr_d[ADDR_W-1:8] = data_in[ADDR_W-9:0];
               else     addr_d[7:0]        = data_in;
            end
            XA_DATA: begin
               if (!bs1) begin
                  dlo_d = data_in;
               end else if (state_q == ST_WRITE_LOAD && cmd_q == CMD_WRITE) begin
                  pb_we_d    = 1'b1;
                  pb_idx_d   = addr_q[PI_W-1:0];
                  pb_wdata_d = {data_in, dlo_q};
               end
            end
            XA_CMD: begin
               // A chip erase requested during a CPU fetch is dropped outright, not deferred.
               if (cmd_known(data_in) && !(data_in == CMD_CHIP_ERASE && pc_rd)) begin
                  cmd_d   = data_in;
                  cmd_evt = 1'b1;
               end
            end
            default: ;
         endcase
      end

      unique case (state_q)
         ST_IDLE: begin
            if (cmd_evt) begin
               if (cmd_d == CMD_WRITE) begin
                  state_d = ST_WRITE_LOAD;
               end else if (cmd_d == CMD_READ && !pc_rd) begin
                  state_d = ST_READ;
               end else if (cmd_d == CMD_CHIP_ERASE) begin
                  state_d = ST_CHIP_ERASE;
                  timer_d = C_LD;
               end
            end
         end
         ST_WRITE_LOAD: begin
            // addr_d so a same-cycle address load lands in the page being erased.
            if (wr_fall) begin
               state_d     = ST_PAGE_ERASE;
               timer_d     = E_LD;
               busy_addr_d = addr_d;
            end else if (cmd_evt && cmd_d == CMD_NOP) begin
               state_d = ST_IDLE;
            end
         end
         ST_PAGE_ERASE: begin
            if (timer_q == '0) begin
               state_d = ST_PAGE_PROG;
               timer_d = P_LD;
            end else begin
               timer_d = timer_q - TMR_W'(1);
            end
         end
         ST_PAGE_PROG: begin
            if (timer_q == '0) state_d = ST_WRITE_LOAD;
            else               timer_d = timer_q - TMR_W'(1);
         end
         ST_CHIP_ERASE: begin
            if (timer_q == '0) state_d = ST_IDLE;
            else               timer_d = timer_q - TMR_W'(1);
         end
         ST_READ: begin
            if (cmd_evt && cmd_d == CMD_NOP) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d       = (state_d == ST_PAGE_ERASE) || (state_d == ST_PAGE_PROG) ||
                     (state_d == ST_CHIP_ERASE);
      rdy_d        = !busy_d;
      erase_d      = (state_d == ST_PAGE_ERASE);
      prog_d       = (state_d == ST_PAGE_PROG);
      chip_erase_d = (state_d == ST_CHIP_ERASE);

      pc_boot   = &pc[ADDR_W-1 -: BOOT_MSBS];
      page_boot = &busy_addr_d[ADDR_W-1 -: BOOT_MSBS];
      same_sec  = (state_d == ST_CHIP_ERASE) || (pc_boot == page_boot);
      rd_now    = (state_q == ST_READ) && !oe_n && !pc_rd;

      bksel_d     = BKSEL_IDLE;
      cpu_stall_d = 1'b0;
      mem_rd_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      if (busy_d) begin
         if (pc_rd && !same_sec) begin
            bksel_d    = pc_boot ? BKSEL_BOOT : BKSEL_APP;
            mem_rd_d   = 1'b1;
            mem_addr_d = pc;
         end else begin
            bksel_d     = BKSEL_PROG;
            cpu_stall_d = pc_rd;
            mem_addr_d  = busy_addr_d;
         end
      end else if (pc_rd) begin
         mem_rd_d   = 1'b1;
         mem_addr_d = pc;
      end else if (rd_now) begin
         mem_rd_d   = 1'b1;
         mem_addr_d = addr_d;
      end

      // Data is presented only for a read issued last cycle and still enabled now.
      rd_iss_d  = rd_now;
      data_oe_d = rd_iss_q && rd_now;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         addr_q       <= '0;
         dlo_q        <= '0;
         cmd_q        <= CMD_NOP;
         timer_q      <= '0;
         busy_addr_q  <= '0;
         rdy_q        <= 1'b1;
         erase_q      <= 1'b0;
         prog_q       <= 1'b0;
         chip_erase_q <= 1'b0;
         pb_we_q      <= 1'b0;
         pb_idx_q     <= '0;
         pb_wdata_q   <= '0;
         mem_rd_q     <= 1'b0;
         mem_addr_q   <= '0;
         rd_iss_q     <= 1'b0;
         data_oe_q    <= 1'b0;
         bksel_q      <= BKSEL_IDLE;
         cpu_stall_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         dlo_q        <= dlo_d;
         cmd_q        <= cmd_d;
         timer_q      <= timer_d;
         busy_addr_q  <= busy_addr_d;
         rdy_q        <= rdy_d;
         erase_q      <= erase_d;
         prog_q       <= prog_d;
         chip_erase_q <= chip_erase_d;
         pb_we_q      <= pb_we_d;
         pb_idx_q     <= pb_idx_d;
         pb_wdata_q   <= pb_wdata_d;
         mem_rd_q     <= mem_rd_d;
         mem_addr_q   <= mem_addr_d;
         rd_iss_q     <= rd_iss_d;
         data_oe_q    <= data_oe_d;
         bksel_q      <= bksel_d;
         cpu_stall_q  <= cpu_stall_d;
      end
   end

   assign rdy        = rdy_q;
   assign erase      = erase_q;
   assign prog       = prog_q;
   assign chip_erase = chip_erase_q;
   assign pb_we      = pb_we_q;
   assign pb_idx     = pb_idx_q;
   assign pb_wdata   = pb_wdata_q;
   assign mem_rd     = mem_rd_q;
   assign mem_addr   = mem_addr_q;
   assign data_oe    = data_oe_q;
   assign bksel      = bksel_q;
   assign cpu_stall  = cpu_stall_q;
   // The array returns data the cycle after mem_rd, so the byte mux sits after the flop.
   assign data_out   = data_oe_q ? (bs1 ? mem_rdata[15:8] : mem_rdata[7:0]) : 8'h00;

endmodule
